// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first,
// with valid/ready handshakes on operand input and result output.
//
//   state | meaning
//   IDLE  | ready for a new operand pair
//   RUN   | adding one bit per clock, WIDTH cycles
//   DONE  | result presented, waiting for out_ready
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_q;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q;
  logic             fa_s, fa_co;
  logic             last_bit;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // new sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
  assign sum_next = (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign last_bit = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            sum_sr  <= '0;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= sum_next;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + 1'b1;
          // outputs only change on DONE entry so they hold the previous result meanwhile
          if (last_bit) begin
            sum_q  <= sum_next;
            cout_q <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = rstn && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;

  logic       in_valid8 = 1'b0, out_ready8 = 1'b1, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, cout8, busy8;
  logic [7:0] sum8;

  logic       in_valid1 = 1'b0, out_ready1 = 1'b1, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       in_ready1, out_valid1, cout1, busy1;
  logic [0:0] sum1;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp8[$];
  logic [1:0] exp1[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: a result is consumed at the negedge before its handoff edge.
  always @(negedge clk) begin
    if (rstn && out_valid8 && out_ready8) begin
      if (exp8.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8_unexpected: got %0h expected none", {cout8, sum8});
      end else begin
        check("w8_result", {23'd0, cout8, sum8}, {23'd0, exp8.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && out_valid1 && out_ready1) begin
      if (exp1.size() == 0) begin
        checks++; errors++;
        $display("FAIL w1_unexpected: got %0h expected none", {cout1, sum1});
      end else begin
        check("w1_result", {30'd0, cout1, sum1}, {30'd0, exp1.pop_front()});
      end
    end
  end

  // One WIDTH=8 transaction. hold = cycles out_ready stays low in DONE; spam drives
  // junk operands with in_valid=1 during RUN.
  task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input int hold, input bit spam);
    int k;
    int lat;
    logic [8:0] e;
    e = {1'b0, a} + {1'b0, b} + {8'd0, c};
    out_ready8 = (hold == 0);
    in_valid8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    k = 0;
    while (!in_ready8 && k < 30) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready8) begin
      checks++; errors++;
      $display("FAIL w8_accept_timeout: got in_ready=0 expected 1");
      in_valid8 = 1'b0;
      return;
    end
    @(posedge clk);
    exp8.push_back(e);
    #1 in_valid8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (spam) begin
        in_valid8 = (lat < 5);
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      @(negedge clk);
      if (!out_valid8) begin
        check("w8_run_in_ready", {31'd0, in_ready8}, 32'd0);
        check("w8_run_busy", {31'd0, busy8}, 32'd1);
      end
    end while (!out_valid8 && lat < 40);
    check("w8_latency", lat, 8);
    if (!out_valid8) return;
    for (int i = 0; i < hold; i++) begin
      check("w8_hold_valid", {31'd0, out_valid8}, 32'd1);
      check("w8_hold_in_ready", {31'd0, in_ready8}, 32'd0);
      check("w8_hold_result", {23'd0, cout8, sum8}, {23'd0, e});
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk); #1 out_ready8 = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("w8_valid_drop", {31'd0, out_valid8}, 32'd0);
    check("w8_idle_in_ready", {31'd0, in_ready8}, 32'd1);
    check("w8_result_held", {23'd0, cout8, sum8}, {23'd0, e});
  endtask

  task automatic txn1(input logic a, input logic b, input logic c);
    int k;
    int lat;
    out_ready1 = 1'b1;
    in_valid1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    k = 0;
    while (!in_ready1 && k < 30) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready1) begin
      checks++; errors++;
      $display("FAIL w1_accept_timeout: got in_ready=0 expected 1");
      in_valid1 = 1'b0;
      return;
    end
    @(posedge clk);
    exp1.push_back(2'(a) + 2'(b) + 2'(c));
    #1 in_valid1 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
      @(negedge clk);
    end while (!out_valid1 && lat < 20);
    check("w1_latency", lat, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("w1_valid_drop", {31'd0, out_valid1}, 32'd0);
  endtask

  initial begin
    int k;
    #1 rstn = 1'b0;
    #2;
    check("rst_in_ready", {31'd0, in_ready8}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid8}, 32'd0);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_result", {23'd0, cout8, sum8}, 32'd0);
    check("rst_in_ready_w1", {31'd0, in_ready1}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready8}, 32'd1);

    txn8(8'h5A, 8'h33, 1'b0, 0, 1'b0);
    txn8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    txn8(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    txn8(8'hC3, 8'h4E, 1'b1, 5, 1'b0);
    txn8(8'h12, 8'h34, 1'b0, 0, 1'b1);
    txn8(8'hFF, 8'hFF, 1'b1, 0, 1'b0);

    // reset in the middle of RUN drops the transaction
    out_ready8 = 1'b1;
    in_valid8 = 1'b1; a8 = 8'hA5; b8 = 8'h11; cin8 = 1'b0;
    @(posedge clk); #1 in_valid8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrun_out_valid", {31'd0, out_valid8}, 32'd0);
    check("midrun_busy", {31'd0, busy8}, 32'd0);
    check("midrun_result", {23'd0, cout8, sum8}, 32'd0);
    check("midrun_in_ready", {31'd0, in_ready8}, 32'd0);
    #1 rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrun_no_result", {30'd0, busy8, out_valid8}, 32'd0);
    end
    txn8(8'h10, 8'h20, 1'b0, 0, 1'b0);

    for (int i = 0; i < 30; i++)
      txn8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    for (int i = 0; i < 8; i++) begin
      k = i;
      txn1(k[2], k[1], k[0]);
    end
    for (int i = 0; i < 8; i++)
      txn1(1'($urandom), 1'($urandom), 1'($urandom));

    repeat (3) @(posedge clk);
    check("w8_scoreboard_empty", exp8.size(), 0);
    check("w1_scoreboard_empty", exp1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
